// File: rtl/seg_pkg.sv
// Shared types and helpers for the seg_scan_driver display path:
// scan state encoding, 7-segment patterns (a..g, active-high) and BCD split.
package seg_pkg;

    typedef enum logic [1:0] {UNI, GAP1, DEC, GAP2} scan_state_e;

    localparam logic [6:0] SEG_0 = 7'b1111110;
    localparam logic [6:0] SEG_1 = 7'b0110000;
    localparam logic [6:0] SEG_2 = 7'b1101101;
    localparam logic [6:0] SEG_3 = 7'b1111001;
    localparam logic [6:0] SEG_4 = 7'b0110011;
    localparam logic [6:0] SEG_5 = 7'b1011011;
    localparam logic [6:0] SEG_6 = 7'b1011111;
    localparam logic [6:0] SEG_7 = 7'b1110000;
    localparam logic [6:0] SEG_8 = 7'b1111111;
    localparam logic [6:0] SEG_9 = 7'b1111011;

    // {tens, units} of a 0-15 value; tens is 0 or 1
    function automatic logic [7:0] bcd_split(input logic [3:0] val);
        logic [3:0] tens;
        logic [3:0] units;
        if (val >= 4'd10) begin
            tens  = 4'd1;
            units = val - 4'd10;
        end else begin
            tens  = 4'd0;
            units = val;
        end
        return {tens, units};
    endfunction

    // Segment pattern for a decimal digit; non-decimal codes are dark
    function automatic logic [6:0] seg_pattern(input logic [3:0] dig);
        logic [6:0] pat;
        case (dig)
            4'd0:    pat = SEG_0;
            4'd1:    pat = SEG_1;
            4'd2:    pat = SEG_2;
            4'd3:    pat = SEG_3;
            4'd4:    pat = SEG_4;
            4'd5:    pat = SEG_5;
            4'd6:    pat = SEG_6;
            4'd7:    pat = SEG_7;
            4'd8:    pat = SEG_8;
            4'd9:    pat = SEG_9;
            default: pat = 7'b0000000;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Refresh scanner: walks UNI -> GAP1 -> DEC -> GAP2 with per-state dwell
// counts and flags the last cycle of each state.
module seg_scan_timer
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int GAP_CYC     = 500
) (
    input  logic        clk,
    input  logic        rst_n,
    output scan_state_e state_o,
    output logic        last_o
);

    localparam int MAXC = (REFRESH_DIV > GAP_CYC) ? REFRESH_DIV : GAP_CYC;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    scan_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          last;

    // Terminal count per state, next state and counter restart
    always_comb begin
        if (state_q == UNI || state_q == DEC)
            last = (cnt_q == CW'(REFRESH_DIV - 1));
        else
            last = (cnt_q == CW'(GAP_CYC - 1));
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        if (last) begin
            cnt_d = '0;
            case (state_q)
                UNI:     state_d = GAP1;
                GAP1:    state_d = DEC;
                DEC:     state_d = GAP2;
                default: state_d = UNI;
            endcase
        end
    end

    // State and dwell counter; reset parks in GAP2 so the first frame starts cleanly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= GAP2;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign state_o = state_q;
    assign last_o  = last;

endmodule

// File: rtl/seg_scan_driver.sv
// Two-digit 7-segment scan driver: accepts a 0-15 value over valid/ready,
// holds it pending until the frame boundary, then shows tens/units
// time-multiplexed with blanking gaps.
// Optional build macro: LEADING_ZERO_BLANK_EN (dark tens digit when tens=0).
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int GAP_CYC     = 500
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] bin_i,
    input  logic       bin_valid_i,
    output logic       bin_ready_o,
    output logic [6:0] seg_o,
    output logic       dig_uni_o,
    output logic       dig_dec_o,
    output logic       frame_o
);

    scan_state_e state;
    logic        last;

    seg_scan_timer #(
        .REFRESH_DIV(REFRESH_DIV),
        .GAP_CYC    (GAP_CYC)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .state_o(state),
        .last_o (last)
    );

    logic [3:0] pend_q, pend_d;
    logic       pend_full_q, pend_full_d;
    logic [3:0] disp_q, disp_d;
    logic       frame;
    logic [7:0] split;

    assign frame       = (state == GAP2) && last;
    assign bin_ready_o = !pend_full_q;

    // Accept into the empty pending slot; promote to display only at frame end
    always_comb begin
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        disp_d      = disp_q;
        if (bin_valid_i && !pend_full_q) begin
            pend_d      = bin_i;
            pend_full_d = 1'b1;
        end else if (frame && pend_full_q) begin
            disp_d      = pend_q;
            pend_full_d = 1'b0;
        end
    end

    // Handshake and display registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            disp_q      <= '0;
        end else begin
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            disp_q      <= disp_d;
        end
    end

    // Output decode straight from state and display register
    always_comb begin
        split     = bcd_split(disp_q);
        seg_o     = 7'b0000000;
        dig_uni_o = 1'b0;
        dig_dec_o = 1'b0;
        case (state)
            UNI: begin
                dig_uni_o = 1'b1;
                seg_o     = seg_pattern(split[3:0]);
            end
            DEC: begin
`ifdef LEADING_ZERO_BLANK_EN
                if (split[7:4] != 4'd0) begin
                    dig_dec_o = 1'b1;
                    seg_o     = seg_pattern(split[7:4]);
                end
`else
                dig_dec_o = 1'b1;
                seg_o     = seg_pattern(split[7:4]);
`endif
            end
            default: ;
        endcase
    end

    assign frame_o = frame;

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
Downstream display stage for the Gray-to-binary path. Accepts a 4-bit binary value (0-15) through a valid/ready handshake and splits it into tens and units digits. Drives both 7-segment digits by time multiplexing, with a blanking gap between digits to suppress ghosting. Replaces the button-driven digit select with an autonomous refresh scanner.

Parameters:
REFRESH_DIV, 50000, clock cycles each digit is lit; legal range >= 2
GAP_CYC, 500, clock cycles with both digit enables off between digits; legal range >= 1

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
bin_i  input  4  binary value to display, 0-15
bin_valid_i  input  1  bin_i is valid
bin_ready_o  output  1  pending register empty; a value can be accepted
seg_o  output  7  segments active-high, seg_o[6]=a ... seg_o[0]=g
dig_uni_o  output  1  units digit enable, active-high
dig_dec_o  output  1  tens digit enable, active-high
frame_o  output  1  one-cycle pulse at frame boundary

Behaviour:
- Reset: clk and rst_n only; reset is asynchronous and active-low. On reset: state=GAP2, cycle counter=0, display register=0, pending empty. Outputs during and after reset: bin_ready_o=1, seg_o=0, dig_uni_o=0, dig_dec_o=0, frame_o=0.
- FSM cycle: UNI -> GAP1 -> DEC -> GAP2 -> UNI.
- UNI and DEC each last REFRESH_DIV cycles; GAP1 and GAP2 each last GAP_CYC cycles. The counter restarts at 0 on every state change.
- Frame period: 2*(REFRESH_DIV+GAP_CYC) cycles.
- Outputs are decoded from the state and display registers, with no extra pipeline stage:
  - UNI: dig_uni_o=1, seg_o=pattern(units).
  - DEC: dig_dec_o=1, seg_o=pattern(tens).
  - GAP1/GAP2: both enables 0 and seg_o=0.
  - At most one enable is high in any cycle.
- BCD split: tens = (value>=10) ? 1 : 0; units = (value>=10) ? value-10 : value. Values 0-15 only; no overflow is possible.
- Segment patterns, a..g:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
  - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011
- Handshake:
  - A transfer occurs on a cycle where bin_valid_i && bin_ready_o; bin_i is captured into the pending register.
  - bin_ready_o = !pending_full. It is registered-state based and does not depend on bin_valid_i combinationally.
  - On the last cycle of GAP2: if pending is full, pending moves to the display register and pending clears. bin_ready_o returns to 1 on the next cycle.
  - The displayed value changes only at the frame boundary, so a frame never shows a torn value.
  - No accept and transfer can collide in one cycle, because accept needs pending empty and transfer needs pending full.
  - bin_valid_i while bin_ready_o=0 is ignored. The upstream holds the value; it is not dropped by this block.
- frame_o=1 on the last cycle of GAP2, regardless of the pending state.
- Reset asserted mid-operation: immediately returns to the reset values. Any pending value is discarded.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined: in DEC, when tens=0, dig_dec_o=0 and seg_o=0 for the whole DEC slot. Timing is unchanged.
- Undefined: the DEC slot always shows tens, including "0" (1111110) with dig_dec_o=1.

Decomposition:
- Package seg_pkg holds:
  - scan state enum typedef {UNI, GAP1, DEC, GAP2};
  - the 10-entry segment pattern constants;
  - function bcd_split(4-bit) returning {tens, units};
  - function seg_pattern(4-bit digit) returning 7 bits, with 0 for digits above 9.
- One sub-module: seg_scan_timer, holding the state register, counter and terminal-count logic. It outputs state and the last-cycle-of-state strobe.
- The top level holds the handshake, the registers and output decode.

Test Plan (REFRESH_DIV=8, GAP_CYC=2):
1. Reset values: assert rst_n=0 mid-sim -> all outputs at reset values on the same cycle. Release -> GAP2 runs 2 cycles with frame_o pulse on cycle 2, then UNI with seg_o=1111110 and dig_uni_o=1 for 8 cycles.
2. Load 13 while idle -> bin_ready_o=0 the next cycle. After the next frame_o: UNI shows 1111001 for 8 cycles; 2 gap cycles with seg_o=0; DEC shows 0110000 for 8 cycles; bin_ready_o=1 after the transfer.
3. Back-pressure: accept 5, then hold bin_valid_i=1 with 9 -> 9 is accepted only on the cycle after the frame boundary. The display shows 5 for one full frame, then 9.
4. Enable check: over 3 frames, dig_uni_o && dig_dec_o is never 1. Each gap shows exactly 2 cycles with both enables 0 and seg_o=0.
5. Reset during DEC with pending full -> pending is discarded, bin_ready_o=1, and the display returns to value 0.
6. Load 7, with and without LEADING_ZERO_BLANK_EN:
   - Defined: the DEC slot has dig_dec_o=0 and seg_o=0.
   - Undefined: the DEC slot has dig_dec_o=1 and seg_o=1111110.
